// File: rtl/pc_pkg.sv
// Shared types and default widths for the program-counter stage.
// Optional trace outputs in pc_unit are enabled by defining PC_UNIT_TRACE_EN.
package pc_pkg;

  localparam int unsigned PC_WIDTH_DEF     = 16;
  localparam int unsigned OFFSET_WIDTH_DEF = 9;
  localparam int unsigned CNT_WIDTH_DEF    = 16;
  localparam logic [PC_WIDTH_DEF-1:0] RESET_VECTOR_DEF = 16'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_e;

  // Sign-extend a default-width branch offset to the default PC width.
  function automatic logic [PC_WIDTH_DEF-1:0] sext_offset(input logic [OFFSET_WIDTH_DEF-1:0] off);
    return PC_WIDTH_DEF'($signed(off));
  endfunction

endpackage

// File: rtl/pc_sext.sv
// Combinational two's-complement sign extender, IN_WIDTH -> OUT_WIDTH.
module pc_sext #(
  parameter int unsigned IN_WIDTH  = 9,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]  raw,
  output logic [OUT_WIDTH-1:0] extended
);

  assign extended = OUT_WIDTH'($signed(raw));

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: edge-detected latch strobe, sequential/relative next PC, halt, retire count.
// Define PC_UNIT_TRACE_EN to add last_src_out / last_taken_out trace registers.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
  input  logic                    clka,
  input  logic                    reset_in,
  input  logic                    pc_latch_in,
  input  logic                    pc_ctl_0_in,
  input  logic [OFFSET_WIDTH-1:0] offset_in,
  input  logic                    halt_in,
  output logic [PC_WIDTH-1:0]     pc_out,
  output logic [PC_WIDTH-1:0]     npc_out,
  output logic                    halted_out,
  output logic                    update_out,
`ifdef PC_UNIT_TRACE_EN
  output logic [PC_WIDTH-1:0]     last_src_out,
  output logic                    last_taken_out,
`endif
  output logic [CNT_WIDTH-1:0]    retired_out
);

  pc_state_e             state;
  pc_state_e             state_next;
  logic                  latch_d;
  logic                  upd_evt;
  logic                  accept;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   pc_seq;
  logic [PC_WIDTH-1:0]   pc_target;
  logic [PC_WIDTH-1:0]   offset_ext;
  logic [CNT_WIDTH-1:0]  retired;
  logic                  update;

  // A strobe held high yields one event; latch_d cleared on reset re-arms it.
  assign upd_evt = pc_latch_in & ~latch_d;

  pc_sext #(
    .IN_WIDTH  (OFFSET_WIDTH),
    .OUT_WIDTH (PC_WIDTH)
  ) u_sext (
    .raw      (offset_in),
    .extended (offset_ext)
  );

  assign pc_seq    = pc + PC_WIDTH'(1);
  assign pc_target = pc_seq + offset_ext;

  always_ff @(posedge clka) begin
    if (reset_in) state <= RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (upd_evt && halt_in) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    accept     = 1'b0;
    halted_out = 1'b0;
    case (state)
      RUN:     accept = upd_evt;
      HALTED:  halted_out = 1'b1;
      default: ;
    endcase
  end

  // HALT retires but leaves the PC in place; retire count saturates.
  always_ff @(posedge clka) begin
    if (reset_in) begin
      latch_d <= 1'b0;
      pc      <= RESET_VECTOR;
      update  <= 1'b0;
      retired <= '0;
    end else begin
      latch_d <= pc_latch_in;
      update  <= accept;
      if (accept && !halt_in) pc <= pc_ctl_0_in ? pc_target : pc_seq;
      if (accept && (retired != '1)) retired <= retired + CNT_WIDTH'(1);
    end
  end

`ifdef PC_UNIT_TRACE_EN
  logic [PC_WIDTH-1:0] last_src;
  logic                last_taken;

  always_ff @(posedge clka) begin
    if (reset_in) begin
      last_src   <= '0;
      last_taken <= 1'b0;
    end else if (accept) begin
      last_src   <= pc;
      last_taken <= pc_ctl_0_in & ~halt_in;
    end
  end

  assign last_src_out   = last_src;
  assign last_taken_out = last_taken;
`endif

  assign pc_out      = pc;
  assign npc_out     = pc_seq;
  assign update_out  = update;
  assign retired_out = retired;

endmodule
